// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal skew feeder for the systolic MAC array
module systolic_skew_feeder #(
  parameter int ARR_SIZE      = 4,
  parameter int HORIZONTAL_BW = 16,
  parameter int LEN_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [LEN_W-1:0]                  i_len,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] i_horizontal,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] i_vertical,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] o_horizontal,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] o_vertical,
  output logic [ARR_SIZE-1:0]               o_lane_valid,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int FW = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             done_q, done_d;
  logic             accept;

  // State register: FSM state, beat/flush counters and the registered done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: a zero-length start is dropped; FLUSH lasts ARR_SIZE cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && (i_len != '0)) begin
          cnt_d   = i_len;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_FLUSH;
            fcnt_d  = FW'(ARR_SIZE - 1);
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake and status decoded from the current state
  always_comb begin
    o_ready = (state_q == S_STREAM);
    o_busy  = (state_q != S_IDLE);
    o_done  = done_q;
    accept  = o_ready && i_valid;
  end

  // Lane i owns a chain of depth i+1; non-accepted cycles inject a zero bubble
  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    logic [(i+1)*HORIZONTAL_BW-1:0] h_q, h_d, v_q, v_d;
    logic [i:0]                     lv_q, lv_d;

    // Chain shift: new word enters at the low end, output taken from the top stage
    always_comb begin
      h_d  = h_q << HORIZONTAL_BW;
      v_d  = v_q << HORIZONTAL_BW;
      lv_d = lv_q << 1;
      h_d[HORIZONTAL_BW-1:0] = accept ? i_horizontal[i*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;
      v_d[HORIZONTAL_BW-1:0] = accept ? i_vertical[i*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;
      lv_d[0] = accept;
    end

    // Chain registers never stall; only reset clears them
    always_ff @(posedge clk) begin
      if (rst) begin
        h_q  <= '0;
        v_q  <= '0;
        lv_q <= '0;
      end else begin
        h_q  <= h_d;
        v_q  <= v_d;
        lv_q <= lv_d;
      end
    end

    assign o_horizontal[i*HORIZONTAL_BW +: HORIZONTAL_BW] = h_q[i*HORIZONTAL_BW +: HORIZONTAL_BW];
    assign o_vertical[i*HORIZONTAL_BW +: HORIZONTAL_BW]   = v_q[i*HORIZONTAL_BW +: HORIZONTAL_BW];
    assign o_lane_valid[i] = lv_q[i];
  end

endmodule
